axis_uart_tx_arbiter: RTL and testbench



---
 rtl/axis_uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_axis_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one 8-bit AXI-stream UART TX sink between NUM_SRC sources.
// The grant is held per packet, and it is cut short by a burst cap or by a stall timeout.
module axis_uart_tx_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int MAX_BURST     = 16,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                                             aclk,
    input  logic                                             aresetn,
    input  logic [8*NUM_SRC-1:0]                             s_tdata,
    input  logic [NUM_SRC-1:0]                               s_tvalid,
    input  logic [NUM_SRC-1:0]                               s_tlast,
    output logic [NUM_SRC-1:0]                               s_tready,
    output logic [7:0]                                       m_tdata,
    output logic                                             m_tvalid,
    output logic                                             m_tlast,
    input  logic                                             m_tready,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] m_tid,
    output logic                                             busy,
    output logic                                             timeout_pulse
);

    localparam int          IDW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned NSRC = NUM_SRC;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   grant, grant_nxt;
    logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [7:0]       beat_cnt, beat_cnt_nxt;
    logic [15:0]      stall_cnt, stall_cnt_nxt;

    logic [2*NUM_SRC-1:0] req_dbl;
    logic [NUM_SRC-1:0]   req_rot;
    logic [IDW:0]         cand;
    logic [IDW-1:0]       winner;
    logic                 any_req;

    logic [7:0] sel_data;
    logic       sel_valid;
    logic       sel_last;
    logic       hs;
    logic       burst_hit;
    logic       stall_hit;
    logic       release_now;

    // Rotate requests so bit 0 is rr_ptr; the first set bit is the winner offset.
    always_comb begin
        req_dbl = {s_tvalid, s_tvalid} >> rr_ptr;
        req_rot = req_dbl[NUM_SRC-1:0];
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (!any_req && req_rot[k[IDW-1:0]]) begin
                any_req = 1'b1;
                cand    = {1'b0, rr_ptr} + {1'b0, k[IDW-1:0]};
                if (cand >= (IDW+1)'(NSRC))
                    cand = cand - (IDW+1)'(NSRC);
                winner = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_data  = 8'(s_tdata >> {grant, 3'b000});
        sel_valid = 1'(s_tvalid >> grant);
        sel_last  = 1'(s_tlast >> grant);
        hs        = (state == BUSY) && sel_valid && m_tready;
        burst_hit = ({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST);
        stall_hit = (state == BUSY) && (STALL_TIMEOUT != 0) && !sel_valid &&
                    (stall_cnt == 16'(STALL_TIMEOUT - 1));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            beat_cnt  <= beat_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        beat_cnt_nxt  = beat_cnt;
        stall_cnt_nxt = stall_cnt;
        release_now   = 1'b0;
        s_tready      = '0;
        m_tdata       = '0;
        m_tvalid      = 1'b0;
        m_tlast       = 1'b0;
        m_tid         = '0;
        busy          = 1'b0;
        timeout_pulse = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt     = winner;
                    beat_cnt_nxt  = '0;
                    stall_cnt_nxt = '0;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                m_tdata       = sel_data;
                m_tvalid      = sel_valid;
                m_tlast       = sel_last;
                s_tready      = {{(NUM_SRC-1){1'b0}}, m_tready} << grant;
                m_tid         = grant;
                busy          = 1'b1;
                timeout_pulse = stall_hit;

                if (hs)
                    beat_cnt_nxt = beat_cnt + 8'd1;

                // Stall counter only runs while the owner has nothing to offer.
                if (sel_valid)
                    stall_cnt_nxt = '0;
                else if (stall_cnt != '1)
                    stall_cnt_nxt = stall_cnt + 16'd1;

                release_now = (hs && (sel_last || burst_hit)) || stall_hit;
                if (release_now) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant == IDW'(NSRC - 1)) ? '0 : grant + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench for axis_uart_tx_arbiter: per-source packet drivers feed the DUT,
// expected beats are queued up front and a monitor checks every beat as it leaves.
module tb_axis_uart_tx_arbiter;

    localparam int NS = 4;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [8*NS-1:0] s_tdata;
    logic [NS-1:0]   s_tvalid;
    logic [NS-1:0]   s_tlast;
    logic [NS-1:0]   s_tready;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [1:0]      m_tid;
    logic            busy;
    logic            timeout_pulse;

    axis_uart_tx_arbiter #(
        .NUM_SRC      (NS),
        .MAX_BURST    (16),
        .STALL_TIMEOUT(8)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .m_tid        (m_tid),
        .busy         (busy),
        .timeout_pulse(timeout_pulse)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct packed {
        int         tid;
        logic [7:0] d;
        logic       l;
        int         gap;   // cycles since previous beat, -1 = unchecked
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] src_q[NS][$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic src_push(input int s, input logic [7:0] d, input logic l);
        src_q[s].push_back({l, d});
    endtask

    task automatic exp_push(input int t, input logic [7:0] d, input logic l, input int g);
        exp_t x;
        x.tid = t;
        x.d   = d;
        x.l   = l;
        x.gap = g;
        exp_q.push_back(x);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({s_tready, m_tvalid, m_tlast, m_tdata, m_tid, busy, timeout_pulse}), 32'd0);
    endtask

    task automatic wait_hs(input logic [7:0] d, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge aclk);
            if (m_tvalid && m_tready && m_tdata == d) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no handshake of 0x%0h within 300 cycles", name, d);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge aclk);
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge aclk);
    endtask

    // Source drivers: present queue head, pop after an accepted beat.
    logic [NS-1:0] drv_hs;
    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge aclk);
            drv_hs = s_tvalid & s_tready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (drv_hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]        = 1'b1;
                    s_tdata[8*i +: 8]  = src_q[i][0][7:0];
                    s_tlast[i]         = src_q[i][0][8];
                end else begin
                    s_tvalid[i]        = 1'b0;
                    s_tdata[8*i +: 8]  = 8'h00;
                    s_tlast[i]         = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted output beat is checked against the scoreboard.
    exp_t mon_e;
    int   last_hs = 0;
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got tid %0d data 0x%0h, want no beat", m_tid, m_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_tid", 32'(m_tid), 32'(mon_e.tid));
                check("beat_data", 32'(m_tdata), 32'(mon_e.d));
                check("beat_last", 32'(m_tlast), 32'(mon_e.l));
                if (mon_e.gap >= 0) check("beat_gap", 32'(cyc - last_hs), 32'(mon_e.gap));
            end
            last_hs = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  k_found;
        bit  bad;
        m_tready = 1'b1;

        // Sources 0 and 1 request continuously from reset: strict alternation, one bubble.
        for (int k = 0; k < 3; k++) begin
            src_push(0, 8'(8'hA0 + k), 1'b1);
            src_push(1, 8'(8'hB0 + k), 1'b1);
            exp_push(0, 8'(8'hA0 + k), 1'b1, (k == 0) ? -1 : 2);
            exp_push(1, 8'(8'hB0 + k), 1'b1, 2);
        end
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset_outputs");
        @(posedge aclk);
        #2 aresetn = 1'b1;
        wait_drain("drain_alternate");

        // Source 2 alone, three back-to-back beats.
        src_push(2, 8'h41, 1'b0);
        src_push(2, 8'h42, 1'b0);
        src_push(2, 8'h43, 1'b1);
        exp_push(2, 8'h41, 1'b0, -1);
        exp_push(2, 8'h42, 1'b0, 1);
        exp_push(2, 8'h43, 1'b1, 1);
        wait_hs(8'h43, "hs_43");
        @(negedge aclk);
        check("busy_after_last", 32'(busy), 32'd0);
        wait_drain("drain_src2");

        // Search must resume at source 3, ahead of source 0.
        src_push(0, 8'hC0, 1'b1);
        src_push(3, 8'hD0, 1'b1);
        exp_push(3, 8'hD0, 1'b1, -1);
        exp_push(0, 8'hC0, 1'b1, 2);
        wait_drain("drain_rr_from_3");

        // Source 3 sends 20 beats; burst cap splits it around source 0.
        for (int k = 1; k <= 20; k++) src_push(3, 8'(k), (k == 20));
        for (int k = 1; k <= 16; k++) exp_push(3, 8'(k), 1'b0, (k == 1) ? -1 : 1);
        exp_push(0, 8'hE0, 1'b1, 2);
        for (int k = 17; k <= 20; k++) exp_push(3, 8'(k), (k == 20), (k == 17) ? 2 : 1);
        repeat (3) @(negedge aclk);
        src_push(0, 8'hE0, 1'b1);
        wait_drain("drain_burst");

        // Source 1 sends one beat then goes silent: timeout release.
        src_push(1, 8'h55, 1'b0);
        exp_push(1, 8'h55, 1'b0, -1);
        wait_hs(8'h55, "hs_55");
        k_found = 0;
        for (int k = 1; k <= 30 && k_found == 0; k++) begin
            @(negedge aclk);
            if (timeout_pulse) k_found = k;
        end
        check("timeout_delay", 32'(k_found), 32'd8);
        @(negedge aclk);
        check("busy_after_timeout", 32'(busy), 32'd0);
        check("pulse_single_cycle", 32'(timeout_pulse), 32'd0);
        wait_drain("drain_timeout");

        // Backpressure for 50 cycles mid-packet on source 2.
        for (int k = 0; k < 4; k++) src_push(2, 8'(8'h61 + k), (k == 3));
        exp_push(2, 8'h61, 1'b0, -1);
        exp_push(2, 8'h62, 1'b0, -1);
        exp_push(2, 8'h63, 1'b0, 1);
        exp_push(2, 8'h64, 1'b1, 1);
        wait_hs(8'h61, "hs_61");
        @(posedge aclk);
        #1 m_tready = 1'b0;
        bad = 1'b0;
        repeat (50) begin
            @(negedge aclk);
            if (s_tready !== '0 || timeout_pulse !== 1'b0 || busy !== 1'b1 ||
                m_tvalid !== 1'b1 || m_tdata !== 8'h62) bad = 1'b1;
        end
        check("backpressure_hold", 32'(bad), 32'd0);
        @(posedge aclk);
        #1 m_tready = 1'b1;
        wait_drain("drain_backpressure");

        // Asynchronous reset mid-packet on source 3.
        for (int k = 0; k < 6; k++) src_push(3, 8'(8'h71 + k), (k == 5));
        exp_push(3, 8'h71, 1'b0, -1);
        exp_push(3, 8'h72, 1'b0, 1);
        wait_hs(8'h72, "hs_72");
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_mid_tready", 32'(s_tready), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        for (int s = 0; s < NS; s++) src_q[s].delete();
        for (int s = 0; s < NS; s++) begin
            src_push(s, 8'(8'h80 + s), 1'b1);
            exp_push(s, 8'(8'h80 + s), 1'b1, (s == 0) ? -1 : 2);
        end
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset_hold_requests");
        @(posedge aclk);
        #2 aresetn = 1'b1;
        wait_drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
